axi_burst_write_master: RTL and testbench

AXI write-side initiator that drives the write address, write data and write response channels of the team's AXI memory slave.
- Accepts a job (base word address, word count) plus a valid/ready input data stream.
- Splits the job into INCR bursts of at most MAX_BURST beats, issues AW/W per burst and collects B for each.
- Sits between the image-processing pipeline output and the memory slave; used to dump processed frames into memory.

---
 rtl/axi_burst_write_master_if.sv | 38 +++
 rtl/axi_burst_write_master.sv | 141 ++++++++++++++
 tb/tb_axi_burst_write_master.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_write_master_if.sv
// Write-side AXI channel bundle (AW, W, B) between a burst write initiator and a
// word-addressed memory slave.
//   master modport: drives awaddr/awlen/awvalid, wdata/wlast/wvalid, bready.
//   slave modport : drives awready, wready, bresp/bvalid.
interface axi_burst_write_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_burst_write_master.sv
// AXI burst write initiator. Takes a job (base word address, word count), splits it
// into INCR bursts of at most MAX_BURST beats and streams the input data onto W.
// One burst in flight at a time: the next AW is only issued after the B response.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, base_addr,   job request (sampled only when idle), first word address,
//   total_words         number of words
//   busy, done, error   job active, one-cycle end pulse, sticky nonzero bresp seen
//   s_data/s_valid/     input stream; a word is consumed only on a W handshake
//   s_ready
//   axi                 AW/W/B channels (master side)
module axi_burst_write_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  total_words,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    axi_burst_write_master_if.master axi
);

    typedef enum logic [2:0] {StIdle, StAddr, StData, StResp, StDone} state_e;

    localparam logic [CNT_WIDTH-1:0] MaxLen = CNT_WIDTH'(MAX_BURST);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic [7:0]            beat_q, beat_d;
    logic                  error_q, error_d;

    logic [CNT_WIDTH-1:0]  burst_len;
    logic [CNT_WIDTH-1:0]  last_beat;
    logic                  at_last_beat;

    // rem_q only changes in StResp, so the current burst length stays valid
    // from AW issue through the final W beat.
    assign burst_len    = (rem_q > MaxLen) ? MaxLen : rem_q;
    assign last_beat    = burst_len - CNT_WIDTH'(1);
    assign at_last_beat = (CNT_WIDTH'(beat_q) == last_beat);
    assign error        = error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        beat_d      = beat_q;
        error_d     = error_q;
        busy        = 1'b0;
        done        = 1'b0;
        s_ready     = 1'b0;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = s_data;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        axi.bready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // A zero-length job is still an accepted job: it clears the
                    // sticky error and completes with no bus traffic.
                    error_d = 1'b0;
                    if (total_words != '0) begin
                        addr_d  = base_addr;
                        rem_d   = total_words;
                        state_d = StAddr;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StAddr: begin
                busy        = 1'b1;
                axi.awvalid = 1'b1;
                axi.awaddr  = addr_q;
                axi.awlen   = 8'(last_beat);
                if (axi.awready) begin
                    beat_d  = '0;
                    state_d = StData;
                end
            end
            StData: begin
                busy       = 1'b1;
                axi.wvalid = s_valid;
                axi.wlast  = at_last_beat;
                s_ready    = axi.wready;
                if (s_valid && axi.wready) begin
                    beat_d = beat_q + 8'd1;
                    if (at_last_beat) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                busy       = 1'b1;
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    error_d = error_q | (axi.bresp != 2'b00);
                    addr_d  = addr_q + ADDR_WIDTH'(burst_len);
                    rem_d   = rem_q - burst_len;
                    state_d = (rem_q == burst_len) ? StDone : StAddr;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_axi_burst_write_master.sv
module tb_axi_burst_write_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] total_words;
    logic          busy, done, error;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready;

    axi_burst_write_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_burst_write_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .total_words(total_words), .busy(busy), .done(done), .error(error),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .axi(axi)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Environment: 0 = always ready, 1 = test-plan back-pressure, 2 = random
    int            mode = 0;
    int            err_burst = -1;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] job_data[$];

    // Observed traffic for the current job
    logic [AW-1:0] aw_addr_log[$];
    logic [7:0]    aw_len_log[$];
    logic [DW-1:0] w_data_log[$];
    logic          w_last_log[$];
    int            b_count, done_count, awv_seen, wv_seen, aw_unstable, hs_mismatch;

    // Memory slave model
    logic [DW-1:0] mem [bit [AW-1:0]];
    logic [AW-1:0] wr_ptr;
    int            pending_b, aw_wait;
    int            cyc = 0;
    bit            aw_hold = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [7:0]    hold_len;

    task automatic clear_logs();
        aw_addr_log.delete(); aw_len_log.delete();
        w_data_log.delete();  w_last_log.delete();
        b_count = 0; done_count = 0; awv_seen = 0; wv_seen = 0;
        aw_unstable = 0; hs_mismatch = 0; pending_b = 0; aw_wait = 0;
    endtask

    // Drive slave/source at negedge, observe the upcoming edge's handshakes at +1.
    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        s_valid = 1'b0; s_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            case (mode)
                0: begin
                    axi.awready = 1'b1;
                    axi.wready  = 1'b1;
                    s_valid     = (src_q.size() != 0);
                    axi.bvalid  = (pending_b > 0);
                end
                1: begin
                    axi.awready = (aw_wait >= 5);
                    axi.wready  = cyc[0];
                    s_valid     = (src_q.size() != 0) && (cyc % 3 != 0);
                    axi.bvalid  = (pending_b > 0);
                end
                default: begin
                    axi.awready = ($urandom_range(0, 2) != 0);
                    axi.wready  = ($urandom_range(0, 2) != 0);
                    s_valid     = (src_q.size() != 0) && ($urandom_range(0, 3) != 0);
                    axi.bvalid  = (pending_b > 0) && ($urandom_range(0, 1) != 0);
                end
            endcase
            s_data    = (src_q.size() != 0) ? src_q[0] : '0;
            axi.bresp = (b_count == err_burst) ? 2'b10 : 2'b00;
            #1;
            if (axi.awvalid) begin
                awv_seen++;
                aw_wait++;
                if (aw_hold && (axi.awaddr !== hold_addr || axi.awlen !== hold_len))
                    aw_unstable++;
            end else begin
                aw_wait = 0;
            end
            aw_hold   = axi.awvalid && !axi.awready;
            hold_addr = axi.awaddr;
            hold_len  = axi.awlen;
            if (axi.awvalid && axi.awready) begin
                aw_addr_log.push_back(axi.awaddr);
                aw_len_log.push_back(axi.awlen);
                wr_ptr  = axi.awaddr;
                aw_wait = 0;
            end
            if (axi.wvalid) wv_seen++;
            if ((axi.wvalid && axi.wready) !== (s_valid && s_ready)) hs_mismatch++;
            if (axi.wvalid && axi.wready) begin
                w_data_log.push_back(axi.wdata);
                w_last_log.push_back(axi.wlast);
                mem[wr_ptr] = axi.wdata;
                wr_ptr      = wr_ptr + 1;
                if (src_q.size() != 0) void'(src_q.pop_front());
                if (axi.wlast) pending_b++;
            end
            if (axi.bvalid && axi.bready) begin
                b_count++;
                pending_b--;
            end
            if (done) done_count++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic fill_random(input int n);
        job_data.delete();
        for (int i = 0; i < n; i++) job_data.push_back($urandom);
    endtask

    // Runs one job on job_data and checks it against the burst-splitting model.
    task automatic run_job(input logic [AW-1:0] base, input int n, input int m, input int eb);
        int            k;
        int            nb;
        int            r;
        int            l;
        logic [AW-1:0] a;
        logic [AW-1:0] exp_addr[$];
        logic [7:0]    exp_len[$];
        logic          exp_last[$];
        clear_logs();
        mode      = m;
        err_burst = eb;
        src_q     = job_data;
        base_addr = base;
        total_words = CW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (n == 0) begin
            check("zero_done_latency", done, 1'b1);
        end else begin
            check("start_busy", busy, 1'b1);
            check("start_awvalid", axi.awvalid, 1'b1);
            check("start_awaddr", axi.awaddr, base);
            check("start_error_clear", error, 1'b0);
        end
        k = 0;
        while (done !== 1'b1 && k < 4000) begin
            tick();
            k++;
        end
        check("done_timeout", (k < 4000), 1'b1);
        check("done_busy_low", busy, 1'b0);
        tick();
        check("done_one_cycle", done, 1'b0);
        check("done_count", done_count, 1);

        // Model: consecutive bursts of min(remaining, MB) words, addresses wrap.
        a = base;
        r = n;
        while (r > 0) begin
            l = (r > int'(MB)) ? int'(MB) : r;
            exp_addr.push_back(a);
            exp_len.push_back(8'(l - 1));
            for (int i = 0; i < l; i++) exp_last.push_back(i == l - 1);
            a = a + AW'(l);
            r = r - l;
        end
        nb = exp_addr.size();

        check("aw_count", aw_addr_log.size(), nb);
        for (int i = 0; i < nb && i < aw_addr_log.size(); i++) begin
            check("awaddr", aw_addr_log[i], exp_addr[i]);
            check("awlen", aw_len_log[i], exp_len[i]);
        end
        check("w_count", w_data_log.size(), n);
        for (int i = 0; i < n && i < w_data_log.size(); i++) begin
            check("wdata", w_data_log[i], job_data[i]);
            check("wlast", w_last_log[i], exp_last[i]);
        end
        check("b_count", b_count, nb);
        check("aw_stable", aw_unstable, 0);
        check("stream_handshake", hs_mismatch, 0);
        check("stream_drained", src_q.size(), 0);
        if (n == 0) begin
            check("zero_no_awvalid", awv_seen, 0);
            check("zero_no_wvalid", wv_seen, 0);
        end else begin
            check("error", error, (eb >= 0 && eb < nb));
            for (int i = 0; i < n; i++) begin
                a = base + AW'(i);
                check("readback", mem.exists(a) ? mem[a] : 'x, job_data[i]);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_awvalid"}, axi.awvalid, 1'b0);
        check({tag, "_wvalid"}, axi.wvalid, 1'b0);
        check({tag, "_wlast"}, axi.wlast, 1'b0);
        check({tag, "_bready"}, axi.bready, 1'b0);
        check({tag, "_s_ready"}, s_ready, 1'b0);
        check({tag, "_awaddr"}, axi.awaddr, '0);
        check({tag, "_awlen"}, axi.awlen, '0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        total_words = '0;
        clear_logs();
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();
        check_outputs_zero("idle");

        // Single short burst with fixed data
        job_data = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 32'h87654321};
        run_job(32'h0, 4, 0, -1);

        // Three bursts: 16, 16, 8
        fill_random(40);
        run_job(32'h100, 40, 0, -1);

        // Back-pressure on every channel
        fill_random(4);
        run_job(32'h200, 4, 1, -1);
        fill_random(37);
        run_job(32'h300, 37, 1, -1);

        // Error on second burst is sticky past done, cleared by next job
        fill_random(40);
        run_job(32'h400, 40, 0, 1);
        tick();
        tick();
        tick();
        check("error_sticky", error, 1'b1);
        fill_random(20);
        run_job(32'h500, 20, 2, -1);

        // Zero-length job
        job_data.delete();
        run_job(32'h600, 0, 0, -1);

        // Reset in the middle of the data phase
        clear_logs();
        mode = 0;
        err_burst = -1;
        fill_random(4);
        src_q = job_data;
        base_addr = 32'h700;
        total_words = CW'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (w_data_log.size() < 2 && k < 100) begin
            tick();
            k++;
        end
        check("mid_rst_reach_data", (k < 100), 1'b1);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_rst");
        tick();
        tick();
        src_q.delete();
        clear_logs();
        rst = 1'b0;
        tick();
        fill_random(4);
        run_job(32'h800, 4, 0, -1);

        // Randomized jobs, some straddling the address wrap
        for (int j = 0; j < 16; j++) begin
            logic [AW-1:0] b;
            int            n;
            int            eb;
            b  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + AW'($urandom_range(0, 31)))
                                             : AW'($urandom);
            n  = $urandom_range(1, 60);
            eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
            fill_random(n);
            run_job(b, n, $urandom_range(0, 2), eb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
